// File: rtl/playfield_pkg.sv
// Shared types and constants for the Tetris-style playfield grid.
// Holds the cell colour encoding, the lock/clear FSM states, the default
// grid dimensions and a saturating 16-bit adder used by the counters.
package playfield_pkg;

   localparam int DEF_GRID_COLS = 10;
   localparam int DEF_GRID_ROWS = 20;

   // 2'b00 is an empty cell; any other code is an occupied cell.
   typedef enum logic [1:0] {
      EMPTY  = 2'b00,
      RED    = 2'b01,
      GREEN  = 2'b10,
      YELLOW = 2'b11
   } color_t;

   typedef enum logic [2:0] {
      IDLE,
      LOCK,
      SCAN,
      SHIFT,
      DONE
   } state_t;

   // a + b, clamped to 16'hFFFF instead of wrapping.
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/playfield_grid_if.sv
// Lock handshake between the falling-piece stage (master) and the
// playfield grid (slave). The master holds lock_valid and its payload
// until it sees lock_ready.
interface playfield_grid_if;

   logic       lock_valid;
   logic [9:0] lock_x;
   logic [9:0] lock_y;
   logic [1:0] lock_color;
   logic       lock_ready;

   modport master (
      output lock_valid, lock_x, lock_y, lock_color,
      input  lock_ready
   );

   modport slave (
      input  lock_valid, lock_x, lock_y, lock_color,
      output lock_ready
   );

endinterface

// File: rtl/playfield_row_full.sv
// Combinational row-full detector: high when every cell of the row holds
// a non-empty colour.
module playfield_row_full
   import playfield_pkg::*;
#(
   parameter int GRID_COLS = DEF_GRID_COLS
) (
   input  color_t row_i [GRID_COLS],
   output logic   full_o
);

   // Any empty cell breaks the row.
   always_comb begin
      full_o = 1'b1;
      for (int c = 0; c < GRID_COLS; c++) begin
         if (row_i[c] == EMPTY) full_o = 1'b0;
      end
   end

endmodule

// File: rtl/playfield_grid.sv
// Playfield grid: stores the locked cells, maps a stopped piece's pixel
// centre onto a cell, then scans bottom-up and collapses full rows one row
// per cycle. Read ports for the VGA renderer and the collision query are
// combinational on the registered grid.
// Optional feature: define PLAYFIELD_SCORE_EN to add the saturating
// score output (+10 per cleared row).
// GRID_COLS must be <= 16 and GRID_ROWS <= 32 to fit the read-port widths.
module playfield_grid
   import playfield_pkg::*;
#(
   parameter int GRID_COLS  = DEF_GRID_COLS,
   parameter int GRID_ROWS  = DEF_GRID_ROWS,
   parameter int GRID_X0    = 240,
   parameter int GRID_Y0    = 80,
   parameter int CELL_SHIFT = 4
) (
   input  logic              frame_clk,
   input  logic              Reset_n,
   playfield_grid_if.slave   lock_if,
   output logic              lock_oob,
   output logic              busy,
   output logic              clear_done,
   output logic [15:0]       lines_total,
`ifdef PLAYFIELD_SCORE_EN
   output logic [15:0]       score,
`endif
   input  logic [3:0]        rd_col,
   input  logic [4:0]        rd_row,
   output logic [1:0]        rd_color,
   input  logic [3:0]        q_col,
   input  logic [4:0]        q_row,
   output logic              q_occupied
);

   localparam logic signed [10:0] X0_S   = 11'(GRID_X0);
   localparam logic signed [10:0] Y0_S   = 11'(GRID_Y0);
   localparam logic signed [10:0] COLS_S = 11'(GRID_COLS);
   localparam logic signed [10:0] ROWS_S = 11'(GRID_ROWS);
   localparam logic [4:0]         COLS_5 = 5'(GRID_COLS);
   localparam logic [5:0]         ROWS_6 = 6'(GRID_ROWS);
   localparam logic [4:0]         LAST_ROW = 5'(GRID_ROWS - 1);

   state_t      state_q, state_d;
   logic [4:0]  row_ptr_q, row_ptr_d;     // row under inspection in SCAN
   logic [4:0]  shift_ptr_q, shift_ptr_d; // destination row in SHIFT
   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   color_t      color_q, color_d;
   logic [15:0] lines_q, lines_d;
`ifdef PLAYFIELD_SCORE_EN
   logic [15:0] score_q, score_d;
`endif
   color_t      grid_q [GRID_ROWS][GRID_COLS];
   color_t      grid_d [GRID_ROWS][GRID_COLS];

   // ---------------- pixel -> cell mapping of the registered lock ----------------
   logic signed [10:0] dx, dy, col_full, row_full;
   logic               lock_in_range;
   logic [3:0]         lock_col;
   logic [4:0]         lock_row;

   assign dx       = $signed({1'b0, x_q}) - X0_S;
   assign dy       = $signed({1'b0, y_q}) - Y0_S;
   assign col_full = dx >>> CELL_SHIFT;
   assign row_full = dy >>> CELL_SHIFT;
   // A negative offset (left of / above the grid) or an index past the far
   // edge means the piece stopped outside the playfield.
   assign lock_in_range = !dx[10] && !dy[10] && (col_full < COLS_S) && (row_full < ROWS_S);
   assign lock_col      = col_full[3:0];
   assign lock_row      = row_full[4:0];

   // ---------------- row-full detection on the scanned row ----------------
   color_t scan_row [GRID_COLS];
   logic   scan_full;

   assign scan_row = grid_q[row_ptr_q];

   playfield_row_full #(
      .GRID_COLS (GRID_COLS)
   ) u_row_full (
      .row_i  (scan_row),
      .full_o (scan_full)
   );

   // ---------------- status outputs (Moore) ----------------
   assign lock_if.lock_ready = (state_q == IDLE);
   assign busy               = (state_q != IDLE);
   assign lock_oob           = (state_q == LOCK) && !lock_in_range;
   assign clear_done         = (state_q == DONE);
   assign lines_total        = lines_q;
`ifdef PLAYFIELD_SCORE_EN
   assign score              = score_q;
`endif

   // ---------------- read ports ----------------
   logic rd_in_range, q_in_range;

   assign rd_in_range = ({1'b0, rd_col} < COLS_5) && ({1'b0, rd_row} < ROWS_6);
   assign q_in_range  = ({1'b0, q_col} < COLS_5) && ({1'b0, q_row} < ROWS_6);
   assign rd_color    = rd_in_range ? grid_q[rd_row][rd_col] : EMPTY;
   // Off-grid cells read as occupied so the falling piece treats the
   // playfield border as a wall.
   assign q_occupied  = !q_in_range || (grid_q[q_row][q_col] != EMPTY);

   // Next-state logic for the lock/scan/shift FSM and its datapath.
   // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d     = state_q;
      row_ptr_d   = row_ptr_q;
      shift_ptr_d = shift_ptr_q;
      x_d         = x_q;
      y_d         = y_q;
      color_d     = color_q;
      lines_d     = lines_q;
`ifdef PLAYFIELD_SCORE_EN
      score_d     = score_q;
`endif
      grid_d      = grid_q;

      case (state_q)
         IDLE: begin
            if (lock_if.lock_valid) begin
               x_d     = lock_if.lock_x;
               y_d     = lock_if.lock_y;
               color_d = color_t'(lock_if.lock_color);
               state_d = LOCK;
            end
         end

         LOCK: begin
            // Colour 0 is written as-is; it simply stays "empty".
            if (lock_in_range) grid_d[lock_row][lock_col] = color_q;
            row_ptr_d = LAST_ROW;
            state_d   = SCAN;
         end

         SCAN: begin
            if (scan_full) begin
               shift_ptr_d = row_ptr_q;
               state_d     = SHIFT;
            end else if (row_ptr_q == 5'd0) begin
               state_d = DONE;
            end else begin
               row_ptr_d = row_ptr_q - 5'd1;
            end
         end

         SHIFT: begin
            if (shift_ptr_q == 5'd0) begin
               // Top row has nothing above it: it becomes empty, the row is
               // counted, and the same index is rescanned since it now holds
               // what used to be the row above.
               grid_d[0] = '{default: EMPTY};
               lines_d   = sat_add16(lines_q, 16'd1);
`ifdef PLAYFIELD_SCORE_EN
               score_d   = sat_add16(score_q, 16'd10);
`endif
               state_d   = SCAN;
            end else begin
               grid_d[shift_ptr_q] = grid_q[shift_ptr_q - 5'd1];
               shift_ptr_d         = shift_ptr_q - 5'd1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and grid registers.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         row_ptr_q   <= 5'd0;
         shift_ptr_q <= 5'd0;
         x_q         <= 10'd0;
         y_q         <= 10'd0;
         color_q     <= EMPTY;
         lines_q     <= 16'd0;
`ifdef PLAYFIELD_SCORE_EN
         score_q     <= 16'd0;
`endif
         // NOTE: the grid is flop-based and must clear asynchronously, so it is reset here rather than mapped to a RAM.
         for (int r = 0; r < GRID_ROWS; r++) begin
            for (int c = 0; c < GRID_COLS; c++) begin
               grid_q[r][c] <= EMPTY;
            end
         end
      end else begin
         state_q     <= state_d;
         row_ptr_q   <= row_ptr_d;
         shift_ptr_q <= shift_ptr_d;
         x_q         <= x_d;
         y_q         <= y_d;
         color_q     <= color_d;
         lines_q     <= lines_d;
`ifdef PLAYFIELD_SCORE_EN
         score_q     <= score_d;
`endif
         grid_q      <= grid_d;
      end
   end

endmodule

// File: tb/tb_playfield_grid.sv
// Self-checking bench for playfield_grid. A reference model of the grid
// predicts, per lock, the pass latency, the out-of-range pulse, the line
// and score counters and the final grid; predictions go into a scoreboard
// queue and are compared when the DUT pulses clear_done.
// Define PLAYFIELD_SCORE_EN to also check the score output.
`timescale 1ns/1ps
module tb_playfield_grid;

   localparam int COLS = 10;
   localparam int ROWS = 20;
   localparam int X0   = 240;
   localparam int Y0   = 80;

   logic        frame_clk;
   logic        Reset_n;
   logic        lock_oob, busy, clear_done, q_occupied;
   logic [15:0] lines_total;
   logic [3:0]  rd_col, q_col;
   logic [4:0]  rd_row, q_row;
   logic [1:0]  rd_color;
`ifdef PLAYFIELD_SCORE_EN
   logic [15:0] score;
`endif

   playfield_grid_if lk ();

   playfield_grid dut (
      .frame_clk   (frame_clk),
      .Reset_n     (Reset_n),
      .lock_if     (lk),
      .lock_oob    (lock_oob),
      .busy        (busy),
      .clear_done  (clear_done),
      .lines_total (lines_total),
`ifdef PLAYFIELD_SCORE_EN
      .score       (score),
`endif
      .rd_col      (rd_col),
      .rd_row      (rd_row),
      .rd_color    (rd_color),
      .q_col       (q_col),
      .q_row       (q_row),
      .q_occupied  (q_occupied)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   typedef struct {
      int lat;
      bit oob;
      int lines;
      int score;
   } exp_t;

   exp_t sb_q [$];
   int   m_grid [ROWS][COLS];
   int   m_lines;
   int   m_score;
   int   n_tests;
   int   n_fail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int px(input int c);
      return X0 + 16 * c + 8;
   endfunction

   function automatic int py(input int r);
      return Y0 + 16 * r + 8;
   endfunction

   function automatic int min16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   // Apply one lock to the model: write the cell, remove every full row by
   // compacting the remaining rows downward, and work out the pass length.
   // A row removed while k rows below it are already gone sits at index
   // src+k when it is collapsed and costs one extra scan plus src+k+1 shifts.
   task automatic model_lock(input int x, input int y, input int c, output exp_t e);
      int nxt [ROWS][COLS];
      int dst, cleared;
      bit full;
      e.oob = (x < X0) || (y < Y0) || ((x - X0) / 16 >= COLS) || ((y - Y0) / 16 >= ROWS);
      if (!e.oob) m_grid[(y - Y0) / 16][(x - X0) / 16] = c;
      e.lat   = 2 + ROWS;
      cleared = 0;
      dst     = ROWS - 1;
      for (int r = 0; r < ROWS; r++)
         for (int k = 0; k < COLS; k++) nxt[r][k] = 0;
      for (int src = ROWS - 1; src >= 0; src--) begin
         full = 1'b1;
         for (int k = 0; k < COLS; k++) if (m_grid[src][k] == 0) full = 1'b0;
         if (full) begin
            e.lat += (src + cleared) + 2;
            cleared++;
         end else begin
            for (int k = 0; k < COLS; k++) nxt[dst][k] = m_grid[src][k];
            dst--;
         end
      end
      m_grid  = nxt;
      m_lines = min16(m_lines + cleared);
      m_score = min16(m_score + 10 * cleared);
      e.lines = m_lines;
      e.score = m_score;
   endtask

   // Compare every cell through both read ports against the model.
   task automatic check_grid(input string tag);
      int mism = 0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            rd_row = 5'(r); rd_col = 4'(c);
            q_row  = 5'(r); q_col  = 4'(c);
            #1;
            if (rd_color !== 2'(m_grid[r][c])) mism++;
            if (q_occupied !== (m_grid[r][c] != 0)) mism++;
         end
      end
      check(tag, mism, 0);
   endtask

   // Drive one lock, follow the pass to clear_done and score it. With
   // hold=1 lock_valid stays high after acceptance for the whole pass.
   task automatic run_lock(input int x, input int y, input int c, input bit hold);
      exp_t e;
      int   n, bad;
      bit   seen_oob, done;
      model_lock(x, y, c, e);
      sb_q.push_back(e);
      @(negedge frame_clk);
      lk.lock_valid = 1'b1;
      lk.lock_x     = 10'(x);
      lk.lock_y     = 10'(y);
      lk.lock_color = 2'(c);
      n = 0;
      while (!lk.lock_ready && n < 100) begin
         @(negedge frame_clk);
         n++;
      end
      if (!lk.lock_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
         void'(sb_q.pop_front());
         lk.lock_valid = 1'b0;
         return;
      end
      @(negedge frame_clk);
      if (!hold) lk.lock_valid = 1'b0;
      n = 1; bad = 0; seen_oob = 1'b0; done = 1'b0;
      while (n < 400) begin
         if (lock_oob) seen_oob = 1'b1;
         if (lk.lock_ready || !busy) bad++;
         if (clear_done) begin
            done = 1'b1;
            break;
         end
         @(negedge frame_clk);
         n++;
      end
      e = sb_q.pop_front();
      check("done_seen", 32'(done), 32'd1);
      check("latency", n, e.lat);
      check("oob", 32'(seen_oob), 32'(e.oob));
      check("ready_low_busy", bad, 0);
      check("lines_total", 32'(lines_total), e.lines);
`ifdef PLAYFIELD_SCORE_EN
      check("score", 32'(score), e.score);
`endif
      if (!hold) check_grid("grid");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      n_tests = 0; n_fail = 0;
      m_lines = 0; m_score = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) m_grid[r][c] = 0;
      lk.lock_valid = 1'b0; lk.lock_x = '0; lk.lock_y = '0; lk.lock_color = '0;
      rd_row = '0; rd_col = '0; q_row = '0; q_col = '0;
      Reset_n = 1'b0;
      repeat (3) @(negedge frame_clk);
      Reset_n = 1'b1;
      @(negedge frame_clk);

      // Reset state and out-of-range read behaviour.
      check("rst_ready", 32'(lk.lock_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_oob", 32'(lock_oob), 32'd0);
      check("rst_done", 32'(clear_done), 32'd0);
      check("rst_lines", 32'(lines_total), 32'd0);
`ifdef PLAYFIELD_SCORE_EN
      check("rst_score", 32'(score), 32'd0);
`endif
      check_grid("rst_grid");
      rd_row = 5'd20; rd_col = 4'd0; q_row = 5'd25; q_col = 4'd0; #1;
      check("rd_row_oor", 32'(rd_color), 32'd0);
      check("q_row_oor", 32'(q_occupied), 32'd1);
      rd_row = 5'd0; rd_col = 4'd11; q_row = 5'd0; q_col = 4'd12; #1;
      check("rd_col_oor", 32'(rd_color), 32'd0);
      check("q_col_oor", 32'(q_occupied), 32'd1);

      // Basic lock at the top-left cell.
      run_lock(248, 88, 3, 1'b0);
      rd_row = 5'd0; rd_col = 4'd0; #1;
      check("cell00", 32'(rd_color), 32'd3);

      // Row 19 nearly full plus a marker above it; colour 0 in the gap does
      // not complete the row, a real colour does.
      for (int c = 0; c < 9; c++) run_lock(px(c), py(19), (c % 3) + 1, 1'b0);
      run_lock(px(5), py(18), 2, 1'b0);
      run_lock(px(9), py(19), 0, 1'b0);
      run_lock(px(9), py(19), 1, 1'b0);

      // Out-of-range locks: left of grid, right edge, below, above.
      run_lock(100, 88, 1, 1'b0);
      run_lock(px(10), py(0), 2, 1'b0);
      run_lock(px(0), py(20), 3, 1'b0);
      run_lock(px(0), 40, 2, 1'b0);

      // lock_valid held through a whole pass, then a back-to-back lock.
      run_lock(px(3), py(19), 1, 1'b1);
      run_lock(px(4), py(19), 2, 1'b0);

      // Two rows collapse: rows 18 and 19 filled except column 9. One lock
      // changes a single cell, so the rows complete in consecutive passes,
      // the second one after having shifted down into row 19.
      for (int c = 0; c < 9; c++) run_lock(px(c), py(18), 3, 1'b0);
      for (int c = 0; c < 9; c++) run_lock(px(c), py(19), 2, 1'b0);
      run_lock(px(9), py(19), 1, 1'b0);
      run_lock(px(9), py(19), 3, 1'b0);

      // Asynchronous reset in the middle of a SHIFT pass.
      for (int c = 0; c < 9; c++) run_lock(px(c), py(19), 1, 1'b0);
      @(negedge frame_clk);
      lk.lock_valid = 1'b1; lk.lock_x = 10'(px(9)); lk.lock_y = 10'(py(19)); lk.lock_color = 2'd2;
      n = 0;
      while (!lk.lock_ready && n < 100) begin
         @(negedge frame_clk);
         n++;
      end
      check("shift_accept", 32'(lk.lock_ready), 32'd1);
      @(negedge frame_clk);
      lk.lock_valid = 1'b0;
      repeat (4) @(negedge frame_clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2 Reset_n = 1'b0;
      #1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) m_grid[r][c] = 0;
      m_lines = 0; m_score = 0;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ready", 32'(lk.lock_ready), 32'd1);
      check("mid_rst_lines", 32'(lines_total), 32'd0);
      check("mid_rst_done", 32'(clear_done), 32'd0);
`ifdef PLAYFIELD_SCORE_EN
      check("mid_rst_score", 32'(score), 32'd0);
`endif
      check_grid("mid_rst_grid");
      @(negedge frame_clk);
      Reset_n = 1'b1;
      @(negedge frame_clk);

      // Normal operation resumes after reset.
      run_lock(px(9), py(19), 1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
